// File: rtl/updown_mod_counter_if.sv
// Control and status bundle for updown_mod_counter: the master drives the
// count controls, the slave (the counter) returns the count and its flags.
interface updown_mod_counter_if #(
    parameter int WIDTH = 8
);
    logic             sync_clr;
    logic             load;
    logic [WIDTH-1:0] d;
    logic             enable;
    logic             up;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;
    logic             ovf;

    modport master (
        output sync_clr, load, d, enable, up,
        input  q, tc, wrap, ovf
    );

    modport slave (
        input  sync_clr, load, d, enable, up,
        output q, tc, wrap, ovf
    );
endinterface

// File: rtl/updown_mod_counter.sv
// Up/down counter over 0..MODULUS-1 with load, synchronous clear, step size,
// wrap-or-saturate limit handling, terminal count and sticky overflow.
module updown_mod_counter #(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 256,
    parameter int STEP     = 1,
    parameter int SATURATE = 0
) (
    input logic                 clk,
    input logic                 rst,
    updown_mod_counter_if.slave bus
);
    // One guard bit so q+STEP and q+MODULUS never overflow the compare.
    localparam logic [WIDTH:0]   MAX_E  = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_E  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   STEP_E = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO_Q = {WIDTH{1'b0}};
    localparam bit               SAT    = (SATURATE != 0);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   d_ext;
    logic [WIDTH:0]   sum_up;
    logic             up_over;
    logic             dn_under;

    assign q_ext    = {1'b0, q_q};
    assign d_ext    = {1'b0, bus.d};
    assign sum_up   = q_ext + STEP_E;
    assign up_over  = (sum_up > MAX_E);
    assign dn_under = (q_ext < STEP_E);

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        ovf_d  = ovf_q;
        if (bus.sync_clr) begin
            q_d   = ZERO_Q;
            ovf_d = 1'b0;
        end else if (bus.load) begin
            if (d_ext > MAX_E) begin
                q_d   = MAX_Q;
                ovf_d = 1'b1;
            end else begin
                q_d = bus.d;
            end
        end else if (bus.enable) begin
            if (bus.up) begin
                if (up_over) begin
                    q_d    = SAT ? MAX_Q : WIDTH'(sum_up - MOD_E);
                    wrap_d = 1'b1;
                    ovf_d  = 1'b1;
                end else begin
                    q_d = WIDTH'(sum_up);
                end
            end else begin
                if (dn_under) begin
                    q_d    = SAT ? ZERO_Q : WIDTH'(q_ext + MOD_E - STEP_E);
                    wrap_d = 1'b1;
                    ovf_d  = 1'b1;
                end else begin
                    q_d = WIDTH'(q_ext - STEP_E);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= ZERO_Q;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    // Flags the cycle whose edge will wrap or clip; load and clear suppress it.
    assign bus.tc   = bus.enable & ~bus.sync_clr & ~bus.load & (bus.up ? up_over : dn_under);
    assign bus.q    = q_q;
    assign bus.wrap = wrap_q;
    assign bus.ovf  = ovf_q;
endmodule
